// File: rtl/regfile_pkg.sv
// Shared constants and types for the 32 x 64-bit register file read/write sides.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package regfile_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int NUM_REGS   = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int ZERO_REG   = 31;

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;

  // One-entry output buffer occupancy.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } rd_state_t;

endpackage

// File: rtl/mux_32_1.sv
// One DATA_WIDTH-wide register select from the flattened register array.
// Latency: purely combinational.
// Backpressure: none; selects whatever slot sel names, 0 for slots that do not exist.
//
// Ports:
//   data_in  : flattened register array, slot i = data_in[i*DATA_WIDTH +: DATA_WIDTH]
//   sel      : slot index
//   data_out : selected slot, or 0 when sel >= NUM_REGS
module mux_32_1 #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic [NUM_REGS*DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0]          sel,
  output logic [DATA_WIDTH-1:0]          data_out
);

  // Comparing against every existing slot (instead of indexing) makes
  // addresses past the last slot fall through to zero automatically.
  always_comb begin
    data_out = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sel == ADDR_WIDTH'(i)) begin
        data_out = data_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/regfile_read_port.sv
// Registered dual read port with write forwarding and a one-entry valid/ready output buffer.
// Latency: request accepted at edge k is visible (out_valid=1) right after edge k.
// Backpressure: rd_ready = !out_valid || out_ready; a held result is kept coherent with writes.
//
// Ports:
//   clk, reset                     : rising-edge clock, async active-low reset
//   reg_q                          : flattened register array contents
//   RegWrite/WriteRegister/WriteData : the write port, used for forwarding and refresh
//   rd_valid/rd_ready              : request handshake, ReadRegister1/2 sampled on accept
//   out_valid/out_ready            : result handshake, ReadData1/2 hold the result
module regfile_read_port #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 31
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  input  logic                           RegWrite,
  input  logic [ADDR_WIDTH-1:0]          WriteRegister,
  input  logic [DATA_WIDTH-1:0]          WriteData,
  input  logic                           rd_valid,
  output logic                           rd_ready,
  input  logic [ADDR_WIDTH-1:0]          ReadRegister1,
  input  logic [ADDR_WIDTH-1:0]          ReadRegister2,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH-1:0]          ReadData1,
  output logic [DATA_WIDTH-1:0]          ReadData2
);

  import regfile_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

  // Address names a real, writable register (not the zero register, not past the array).
  function automatic logic is_live(input logic [ADDR_WIDTH-1:0] a);
    return (a != ZERO_ADDR) && (32'(a) < 32'(NUM_REGS));
  endfunction

  rd_state_t             state_q, state_d;
  logic [DATA_WIDTH-1:0] data1_q, data1_d;
  logic [DATA_WIDTH-1:0] data2_q, data2_d;
  logic [ADDR_WIDTH-1:0] addr1_q, addr1_d;
  logic [ADDR_WIDTH-1:0] addr2_q, addr2_d;

  logic [DATA_WIDTH-1:0] slot1, slot2;
  logic [DATA_WIDTH-1:0] rd1_val, rd2_val;
  logic                  accept;
  logic                  full;

  mux_32_1 #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_REGS  (NUM_REGS),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mux1 (
    .data_in (reg_q),
    .sel     (ReadRegister1),
    .data_out(slot1)
  );

  mux_32_1 #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_REGS  (NUM_REGS),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mux2 (
    .data_in (reg_q),
    .sel     (ReadRegister2),
    .data_out(slot2)
  );

  assign full      = (state_q == ST_FULL);
  assign out_valid = full;
  // Depends only on buffer state and out_ready, never on rd_valid.
  assign rd_ready  = !full || out_ready;
  assign accept    = rd_valid && rd_ready;
  assign ReadData1 = data1_q;
  assign ReadData2 = data2_q;

  // Value captured for a fresh request: zero register first, then the write
  // landing this same edge (reg_q still shows the old value), then the array.
  always_comb begin
    rd1_val = slot1;
    if (ReadRegister1 == ZERO_ADDR) begin
      rd1_val = '0;
    end else if (RegWrite && is_live(ReadRegister1) && (WriteRegister == ReadRegister1)) begin
      rd1_val = WriteData;
    end
  end

  always_comb begin
    rd2_val = slot2;
    if (ReadRegister2 == ZERO_ADDR) begin
      rd2_val = '0;
    end else if (RegWrite && is_live(ReadRegister2) && (WriteRegister == ReadRegister2)) begin
      rd2_val = WriteData;
    end
  end

  always_comb begin
    state_d = state_q;
    data1_d = data1_q;
    data2_d = data2_q;
    addr1_d = addr1_q;
    addr2_d = addr2_q;

    if (accept) begin
      state_d = ST_FULL;
      data1_d = rd1_val;
      data2_d = rd2_val;
      addr1_d = ReadRegister1;
      addr2_d = ReadRegister2;
    end else begin
      if (full && out_ready) begin
        state_d = ST_EMPTY;
      end
      // A held result tracks writes to the registers it came from, so it is
      // never stale when finally consumed. Reset parks the addresses on the
      // zero register, which is_live rejects.
      if (full && RegWrite) begin
        if (is_live(addr1_q) && (WriteRegister == addr1_q)) begin
          data1_d = WriteData;
        end
        if (is_live(addr2_q) && (WriteRegister == addr2_q)) begin
          data2_d = WriteData;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
      data1_q <= '0;
      data2_q <= '0;
      addr1_q <= ZERO_ADDR;
      addr2_q <= ZERO_ADDR;
    end else begin
      state_q <= state_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
      addr1_q <= addr1_d;
      addr2_q <= addr2_d;
    end
  end

endmodule

// File: doc/regfile_read_port.md
# regfile_read_port

Registered dual read port for the 32 x 64-bit register file. It sits opposite the write-enable decode tree:
- it selects two registers from the flattened register array and captures them in a one-entry output buffer with a valid/ready handshake;
- it forwards same-cycle write data so a consumer never sees a stale value.

X31 reads as zero regardless of array contents.

## Interface
Parameters:
- DATA_WIDTH, 64, register width
- NUM_REGS, 32, register count
- ADDR_WIDTH, 5, register address width
- ZERO_REG, 31, index hardwired to zero

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- reg_q  in  NUM_REGS*DATA_WIDTH  flattened register array outputs; slot i = reg_q[i*DATA_WIDTH +: DATA_WIDTH]
- RegWrite  in  1  write-port enable (same signal that gates the write decoder)
- WriteRegister  in  ADDR_WIDTH  write address
- WriteData  in  DATA_WIDTH  write data
- rd_valid  in  1  read request valid
- rd_ready  out  1  read request accepted this cycle when high with rd_valid
- ReadRegister1, ReadRegister2  in  ADDR_WIDTH  read addresses, sampled on accept
- out_valid  out  1  ReadData1/2 hold a valid result
- out_ready  in  1  consumer takes result this cycle
- ReadData1, ReadData2  out  DATA_WIDTH  read results

## Operation
- Two states: EMPTY (out_valid=0) and FULL (out_valid=1).
- rd_ready = !out_valid || out_ready, purely combinational. There is no combinational path from rd_valid to rd_ready.
- Accept = rd_valid && rd_ready. On accept, the captured register for port n is loaded with a value chosen in this priority order:
  - ReadRegisterN == ZERO_REG: 0;
  - else RegWrite && WriteRegister == ReadRegisterN: WriteData (forward);
  - else the reg_q slot.
- The captured addresses are stored alongside the data.
- Transitions:
  - EMPTY + accept -> FULL.
  - FULL + out_ready + no accept -> EMPTY.
  - FULL + out_ready + accept -> FULL with new data, with no bubble.
  - FULL + !out_ready: hold, and rd_ready is 0.
- Coherence refresh: while FULL and not being replaced, if RegWrite and WriteRegister equals a captured address (and that address is not ZERO_REG), that port's ReadData is updated to WriteData at the next edge. Both ports refresh if both match.
- Writes to ZERO_REG never affect any output.
- Out-of-range addresses (>= NUM_REGS when NUM_REGS < 2^ADDR_WIDTH) read 0.

## Timing
- Reset (asserted low, asynchronous):
  - out_valid=0;
  - ReadData1/2=0;
  - captured addresses = ZERO_REG, so no refresh can occur.
- rd_ready returns to 1 combinationally while reset is held.
- Latency: a request accepted at edge k has its data visible with out_valid=1 after edge k.
- Throughput: one read per cycle while out_ready stays high.
- Reset mid-operation discards the buffered result. There is no partial output after release.
- Reset release is synchronous to the first rising clk following deassertion. No accept occurs on the deassertion edge itself.

## Structure
- Shared package regfile_pkg:
  - DATA_WIDTH, NUM_REGS, ADDR_WIDTH, ZERO_REG constants;
  - typedef reg_addr_t (logic [ADDR_WIDTH-1:0]);
  - typedef reg_data_t (logic [DATA_WIDTH-1:0]).
- The write-side decoders import the same package.
- Sub-module mux_32_1: one DATA_WIDTH-wide 32:1 select, instantiated once per read port, with zero-register and forward logic outside it.
- The top level holds the state bit, the two data registers, the two captured-address registers and the refresh compare.

## Test plan
- Reset low with garbage on reg_q, then release -> out_valid=0, ReadData1/2=0, rd_ready=1.
- reg_q[3]=0xAAAA, reg_q[7]=0x5555; rd_valid=1, R1=3, R2=7, out_ready=1 -> next cycle out_valid=1, ReadData1=0xAAAA, ReadData2=0x5555.
- Same cycle as accept: RegWrite=1, WriteRegister=3, WriteData=0x1234 while reg_q[3]=0xAAAA -> ReadData1=0x1234. Also R1=31 with a write to 31 of 0xFFFF -> ReadData1=0.
- FULL with out_ready=0, holding R2=7; write 7 <- 0xBEEF -> rd_ready=0, ReadData2 becomes 0xBEEF next cycle, out_valid stays 1.
- Back-to-back reads of 1, 2, 3, 4 with out_ready=1 every cycle -> four consecutive valid cycles with matching data and no bubble. Then assert reset low mid-stream -> out_valid=0 and ReadData=0 immediately, without waiting for a clock edge.
